// File: rtl/special_reg_file.sv
// HI/LO special register file: NCH architectural registers with a registered read port toward EX.
// Latency: one cycle from ID-stage select to rd_data; the WB write is bypassed on the same edge.
// Backpressure: stall[2]/stall[3] hold the read latch or insert a bubble; HILO_FWD_EN selects forwarding over the hazard request.
module special_reg_file #(
    parameter int DW  = 32,
    parameter int NCH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [NCH-1:0]    rd_en,
    input  logic [NCH-1:0]    ex_we,
    input  logic [NCH-1:0]    mem_we,
    input  logic [NCH-1:0]    wb_we,
    input  logic [NCH*DW-1:0] ex_wdata,
    input  logic [NCH*DW-1:0] mem_wdata,
    input  logic [NCH*DW-1:0] wb_wdata,
    output logic [NCH*DW-1:0] rd_data,
    output logic              hazard
);

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    logic [NCH*DW-1:0] arch_q;
    logic [NCH*DW-1:0] sel;
    logic              unused_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arch_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wb_we[i]) begin
                    arch_q[i*DW +: DW] <= wb_wdata[i*DW +: DW];
                end
            end
        end
    end

    // Youngest in-flight producer wins so EX never sees a stale HI/LO.
    always_comb begin
        sel = arch_q;
        for (int i = 0; i < NCH; i++) begin
`ifdef HILO_FWD_EN
            if (ex_we[i]) begin
                sel[i*DW +: DW] = ex_wdata[i*DW +: DW];
            end else if (mem_we[i]) begin
                sel[i*DW +: DW] = mem_wdata[i*DW +: DW];
            end else if (wb_we[i]) begin
                sel[i*DW +: DW] = wb_wdata[i*DW +: DW];
            end
`else
            if (wb_we[i]) begin
                sel[i*DW +: DW] = wb_wdata[i*DW +: DW];
            end
`endif
        end
    end

`ifdef HILO_FWD_EN
    assign hazard    = 1'b0;
    assign unused_in = ^{rd_en, stall[5:4], stall[1:0]};
`else
    // Without EX/MEM forwarding the reader must wait until the producer reaches WB.
    assign hazard    = |(rd_en & (ex_we | mem_we));
    assign unused_in = ^{ex_wdata, mem_wdata, stall[5:4], stall[1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (flush) begin
            rd_data <= '0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            rd_data <= '0;
        end else if (stall[2] == NO_STOP) begin
            rd_data <= sel;
        end
    end

endmodule

// File: tb/tb_special_reg_file.sv
// Table-driven bench for special_reg_file; expected read values go through a scoreboard queue.
module tb_special_reg_file;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  rd_en, ex_we, mem_we, wb_we;
    logic [63:0] ex_wdata, mem_wdata, wb_wdata;
    logic [63:0] rd_data;
    logic        hazard;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [1:0]  rd_en, ex_we, mem_we, wb_we;
        logic [63:0] ex_wdata, mem_wdata, wb_wdata;
        logic [63:0] exp_rd;
        logic        exp_haz;
    } vec_t;

    vec_t tbl[$];
    vec_t tbl2[$];

    special_reg_file #(.DW(32), .NCH(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .rd_en(rd_en),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .ex_wdata(ex_wdata), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
        .rd_data(rd_data), .hazard(hazard)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [5:0] st, input logic fl, input logic [1:0] re,
                                input logic [1:0] exw, input logic [1:0] mw, input logic [1:0] ww,
                                input logic [63:0] exd, input logic [63:0] md, input logic [63:0] wd,
                                input logic [63:0] erd, input logic eh);
        vec_t v;
        v.stall = st; v.flush = fl; v.rd_en = re;
        v.ex_we = exw; v.mem_we = mw; v.wb_we = ww;
        v.ex_wdata = exd; v.mem_wdata = md; v.wb_wdata = wd;
        v.exp_rd = erd; v.exp_haz = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; flush = v.flush; rd_en = v.rd_en;
        ex_we = v.ex_we; mem_we = v.mem_we; wb_we = v.wb_we;
        ex_wdata = v.ex_wdata; mem_wdata = v.mem_wdata; wb_wdata = v.wb_wdata;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1 check($sformatf("%s hazard", tag), {63'd0, hazard}, {63'd0, v.exp_haz});
        exp_q.push_back(v.exp_rd);
        @(posedge clk);
        #1 check($sformatf("%s rd_data", tag), rd_data, exp_q.pop_front());
    endtask

    localparam logic [63:0] Z = 64'h0;

    initial begin
        rst_n = 1'b0;
        drive(mk(6'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0));

        // Common table: identical behaviour with or without forwarding.
        tbl.push_back(mk(6'b000000, 0, 2'b01, 2'b00, 2'b00, 2'b01, Z, Z, {32'h0, 32'h1234_5678}, {32'h0, 32'h1234_5678}, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b10, 2'b00, 2'b00, 2'b10, Z, Z, {32'h55, 32'h0}, {32'h55, 32'h1234_5678}, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'h55, 32'h1234_5678}, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b01, 2'b00, 2'b00, 2'b01, Z, Z, {32'h0, 32'h55}, {32'h55, 32'h55}, 0));
        tbl.push_back(mk(6'b000100, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, Z, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'h55, 32'h55}, 0));
        tbl.push_back(mk(6'b001100, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'h55, 32'h55}, 0));
        tbl.push_back(mk(6'b001100, 0, 2'b00, 2'b00, 2'b00, 2'b11, Z, Z, {32'hAAAA_AAAA, 32'hBBBB_BBBB}, {32'h55, 32'h55}, 0));
        tbl.push_back(mk(6'b001100, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'h55, 32'h55}, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'hAAAA_AAAA, 32'hBBBB_BBBB}, 0));
        tbl.push_back(mk(6'b000000, 1, 2'b00, 2'b10, 2'b00, 2'b00, {32'h77, 32'h0}, Z, Z, Z, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'hAAAA_AAAA, 32'hBBBB_BBBB}, 0));
        tbl.push_back(mk(6'b001100, 1, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, Z, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b01, Z, Z, {32'hDEAD_BEEF, 32'h1}, {32'hAAAA_AAAA, 32'h1}, 0));
        tbl.push_back(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'hAAAA_AAAA, 32'h1}, 0));
        tbl.push_back(mk(6'b000011, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'hAAAA_AAAA, 32'h1}, 0));

`ifdef HILO_FWD_EN
        tbl2.push_back(mk(6'b000000, 0, 2'b11, 2'b01, 2'b01, 2'b01, {32'h0, 32'hA}, {32'h0, 32'hB}, {32'h0, 32'hC}, {32'hAAAA_AAAA, 32'hA}, 0));
        tbl2.push_back(mk(6'b000000, 0, 2'b11, 2'b00, 2'b01, 2'b01, Z, {32'h0, 32'hB}, {32'h0, 32'hC}, {32'hAAAA_AAAA, 32'hB}, 0));
        tbl2.push_back(mk(6'b000000, 0, 2'b11, 2'b00, 2'b00, 2'b01, Z, Z, {32'h0, 32'hC}, {32'hAAAA_AAAA, 32'hC}, 0));
        tbl2.push_back(mk(6'b000000, 0, 2'b11, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'hAAAA_AAAA, 32'hC}, 0));
        tbl2.push_back(mk(6'b000000, 0, 2'b11, 2'b10, 2'b00, 2'b00, {32'h77, 32'h0}, Z, Z, {32'h77, 32'hC}, 0));
        tbl2.push_back(mk(6'b000000, 0, 2'b11, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'hAAAA_AAAA, 32'hC}, 0));
`else
        tbl2.push_back(mk(6'b000000, 0, 2'b10, 2'b00, 2'b10, 2'b00, Z, {32'h99, 32'h0}, Z, {32'hAAAA_AAAA, 32'h1}, 1));
        tbl2.push_back(mk(6'b000000, 0, 2'b01, 2'b00, 2'b10, 2'b00, Z, {32'h99, 32'h0}, Z, {32'hAAAA_AAAA, 32'h1}, 0));
        tbl2.push_back(mk(6'b000000, 0, 2'b01, 2'b01, 2'b00, 2'b00, {32'h0, 32'hFFFF_FFFF}, Z, Z, {32'hAAAA_AAAA, 32'h1}, 1));
        tbl2.push_back(mk(6'b000000, 0, 2'b11, 2'b10, 2'b01, 2'b00, {32'h5, 32'h6}, {32'h7, 32'h8}, Z, {32'hAAAA_AAAA, 32'h1}, 1));
        tbl2.push_back(mk(6'b000000, 0, 2'b00, 2'b11, 2'b00, 2'b00, {32'h5, 32'h6}, Z, Z, {32'hAAAA_AAAA, 32'h1}, 0));
`endif

        repeat (2) @(posedge clk);
        #1 check("reset rd_data", rd_data, Z);
        check("reset hazard", {63'd0, hazard}, Z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i], $sformatf("cfg%0d", i));

        // Asynchronous reset mid-cycle, then a write landing on a reset edge.
        apply(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b11, Z, Z, {64{1'b1}}, {64{1'b1}}, 0), "allones");
        #2 rst_n = 1'b0;
        #1 check("async reset rd_data", rd_data, Z);
        @(negedge clk);
        drive(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b11, Z, Z, {32'h1234, 32'h1234}, Z, 0));
        @(posedge clk);
        #1 check("reset edge rd_data", rd_data, Z);
        rst_n = 1'b1;
        apply(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b01, Z, Z, {32'hDEAD, 32'h5}, {32'h0, 32'h5}, 0), "post-reset write");
        apply(mk(6'b000000, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z, Z, Z, {32'h0, 32'h5}, 0), "post-reset read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/special_reg_file.md
SPECIAL_REG_FILE -- requirements
Module: special_reg_file

Interface
REQ-001 Parameter DW, default 32, data width of each special register.
REQ-002 Parameter NCH, default 2, number of special-register channels (ch0=HI, ch1=LO).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 stall  in  `StallBus  pipeline stall vector; bit2 = ID/EX boundary, bit3 = EX/MEM boundary; `Stop = 1, `NoStop = 0.
REQ-006 flush  in  1  synchronous clear of the read latch.
REQ-007 rd_en  in  NCH  ID-stage instruction reads channel i.
REQ-008 ex_we / mem_we / wb_we  in  NCH each  per-channel write enable from the EX / MEM / WB stage.
REQ-009 ex_wdata / mem_wdata / wb_wdata  in  NCH*DW each  write data; channel i at bits [i*DW +: DW].
REQ-010 rd_data  out  NCH*DW  registered read value presented to EX; same packing.
REQ-011 hazard  out  1  combinational stall request to the stall controller.

Function
REQ-012 Architectural register arch[i] SHALL load wb_wdata[i] on a clock edge when wb_we[i]=1, else hold; writes are independent of stall and flush.
REQ-013 Per channel, the next read value sel[i] SHALL be ex_wdata[i] if ex_we[i], else mem_wdata[i] if mem_we[i], else wb_wdata[i] if wb_we[i], else arch[i] (HILO_FWD_EN defined).
REQ-014 The rd_data latch SHALL update on the clock edge, evaluated in this priority order:
- flush=1 -> all zero
- stall[2]=`Stop and stall[3]=`NoStop -> all zero (bubble)
- stall[2]=`NoStop -> sel
- otherwise -> hold
REQ-015 Read latency SHALL be one cycle: a value selected in cycle N appears on rd_data in cycle N+1.
REQ-016 A simultaneous wb write and read of the same channel SHALL return the written data in the same edge (WB bypass), never the stale arch value.
REQ-017 Channels SHALL be fully independent; a write to channel i SHALL never alter channel j != i.
REQ-018 Arithmetic: none; all data paths are DW bits, no extension or truncation.
REQ-019 hazard SHALL be 0 when HILO_FWD_EN is defined.

Reset
REQ-020 rst_n=0 SHALL immediately, without a clock edge, clear all arch[i] and rd_data to 0.
REQ-021 rst_n deassertion SHALL be synchronised externally; the first edge after release SHALL process normally.
REQ-022 Reset mid-operation SHALL discard any in-flight write arriving on the same edge as reset.

Configuration
REQ-023 Macro HILO_FWD_EN defined: EX/MEM/WB forwarding per REQ-013, hazard tied 0.
REQ-024 HILO_FWD_EN undefined: sel[i] SHALL be wb bypass (REQ-016) else arch[i]; hazard SHALL be OR over i of rd_en[i] & (ex_we[i] | mem_we[i]); EX/MEM write data unused.

Verification
REQ-025 Reset then wb_we=2'b01, wb_wdata={32'h0,32'h1234_5678}, stall=0 -> next cycle rd_data[31:0]=32'h1234_5678, rd_data[63:32]=0.
REQ-026 FWD_EN: ex_we[0]=1 with ex_wdata=32'hA, mem_we[0]=1 with mem_wdata=32'hB, wb_we[0]=1 with wb_wdata=32'hC -> rd_data[31:0]=32'hA; drop ex_we -> 32'hB; drop mem_we -> 32'hC.
REQ-027 stall[2]=1, stall[3]=0 for one cycle -> rd_data=0; stall[2]=1, stall[3]=1 -> rd_data holds its prior value 32'h55 for all cycles stalled.
REQ-028 flush=1 together with stall=0 and ex_we[1]=1, ex_wdata=32'h77 -> rd_data=0 next cycle; arch unchanged.
REQ-029 No FWD_EN: rd_en=2'b10 with mem_we[1]=1 -> hazard=1 same cycle; rd_en=2'b01 -> hazard=0.
REQ-030 rst_n pulsed low mid-cycle with rd_data=32'hFFFF_FFFF -> rd_data=0 before next clock edge.
